// File: rtl/bp_mem_noc_edge_assembler_if.sv
// Link-side and packet-side bundle for bp_mem_noc_edge_assembler.
//   link_v_i / link_data_i / link_ready_and_o : wormhole flit input from the mesh edge
//   pkt_o / pkt_len_o / pkt_v_o / pkt_yumi_i  : assembled packet, valid/yumi to consumer
//   err_o                                     : oversize-packet drop pulse
// modport slave  : assembler view
// modport master : mesh + consumer view
interface bp_mem_noc_edge_assembler_if #(
    parameter int flit_width_p     = 64,
    parameter int len_width_p      = 4,
    parameter int max_body_flits_p = 8
) ();
    localparam int pkt_width_lp = flit_width_p * (max_body_flits_p + 1);

    logic                    link_v_i;
    logic [flit_width_p-1:0] link_data_i;
    logic                    link_ready_and_o;
    logic [pkt_width_lp-1:0] pkt_o;
    logic [len_width_p-1:0]  pkt_len_o;
    logic                    pkt_v_o;
    logic                    pkt_yumi_i;
    logic                    err_o;

    modport slave (
        input  link_v_i, link_data_i, pkt_yumi_i,
        output link_ready_and_o, pkt_o, pkt_len_o, pkt_v_o, err_o
    );

    modport master (
        output link_v_i, link_data_i, pkt_yumi_i,
        input  link_ready_and_o, pkt_o, pkt_len_o, pkt_v_o, err_o
    );
endinterface

// File: rtl/bp_mem_noc_edge_assembler.sv
// Terminates one column's memory-command wormhole link on the south edge.
// Header and body flits are gathered into one wide packet that is offered to
// the memory-side converter with valid/yumi; packets longer than the buffer
// are drained from the link and reported on err_o.
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   bus        : slave modport of bp_mem_noc_edge_assembler_if
//                (link flit input, packet output, error pulse)
module bp_mem_noc_edge_assembler #(
    parameter int flit_width_p     = 64,
    parameter int cord_width_p     = 8,
    parameter int len_width_p      = 4,
    parameter int max_body_flits_p = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    bp_mem_noc_edge_assembler_if.slave         bus
);
    localparam logic [len_width_p-1:0] MaxLen = len_width_p'(max_body_flits_p);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_FULL,
        ST_DRAIN
    } state_e;

    state_e                  r_state;
    state_e                  w_next_state;
    logic [len_width_p-1:0]  r_cnt;
    logic [len_width_p-1:0]  r_len;
    logic                    r_err;
    logic [flit_width_p-1:0] r_buf [max_body_flits_p+1];

    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_hdr_take;
    logic [len_width_p-1:0]  w_hdr_len;
    logic                    w_hdr_oversize;
    logic [len_width_p-1:0]  w_slot;

    assign w_hdr_len      = bus.link_data_i[cord_width_p+len_width_p-1:cord_width_p];
    assign w_hdr_oversize = (w_hdr_len > MaxLen);
    assign w_slot         = r_cnt + 1'b1;
    assign w_xfer         = bus.link_v_i & w_ready;
    // In FULL, ready mirrors yumi, so any transfer there is a back-to-back header.
    assign w_hdr_take     = w_xfer & ((r_state == ST_IDLE) | (r_state == ST_FULL));

    always_comb begin
        w_ready      = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_BODY: begin
                w_ready = 1'b1;
                if (w_xfer && (w_slot == r_len)) begin
                    w_next_state = ST_FULL;
                end
            end
            ST_FULL: begin
                w_ready = bus.pkt_yumi_i;
                if (bus.pkt_yumi_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_ready = 1'b1;
                if (w_xfer && (r_cnt == len_width_p'(1))) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_hdr_take) begin
            if (w_hdr_len == '0) begin
                w_next_state = ST_FULL;
            end else if (w_hdr_oversize) begin
                w_next_state = ST_DRAIN;
            end else begin
                w_next_state = ST_BODY;
            end
        end
        if (!reset_n_i) begin
            w_ready = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
            for (int unsigned k = 0; k < max_body_flits_p + 1; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_err   <= 1'b0;
            if (w_hdr_take) begin
                r_buf[0] <= bus.link_data_i;
                for (int unsigned k = 1; k < max_body_flits_p + 1; k++) begin
                    r_buf[k] <= '0;
                end
                r_len <= w_hdr_len;
                // DRAIN reuses the counter as a remaining-flit count.
                r_cnt <= w_hdr_oversize ? w_hdr_len : '0;
            end else if ((r_state == ST_BODY) && w_xfer) begin
                for (int unsigned k = 1; k < max_body_flits_p + 1; k++) begin
                    if (w_slot == len_width_p'(k)) begin
                        r_buf[k] <= bus.link_data_i;
                    end
                end
                r_cnt <= w_slot;
            end else if ((r_state == ST_DRAIN) && w_xfer) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == len_width_p'(1)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.pkt_o = '0;
        for (int unsigned k = 0; k < max_body_flits_p + 1; k++) begin
            bus.pkt_o[k*flit_width_p +: flit_width_p] = r_buf[k];
        end
    end

    assign bus.link_ready_and_o = w_ready;
    assign bus.pkt_len_o        = r_len;
    assign bus.pkt_v_o          = (r_state == ST_FULL);
    assign bus.err_o            = r_err;

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) bus.pkt_yumi_i |-> bus.pkt_v_o
    ) else $error("pkt_yumi_i asserted while pkt_v_o is low");
`endif
endmodule

// File: tb/tb_bp_mem_noc_edge_assembler.sv
module tb_bp_mem_noc_edge_assembler;
    localparam int FW = 64;
    localparam int LW = 4;
    localparam int MB = 8;
    localparam int PW = FW * (MB + 1);

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    bp_mem_noc_edge_assembler_if #(
        .flit_width_p(FW), .len_width_p(LW), .max_body_flits_p(MB)
    ) bus ();

    bp_mem_noc_edge_assembler #(
        .flit_width_p(FW), .cord_width_p(8), .len_width_p(LW), .max_body_flits_p(MB)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [FW-1:0] d;
        logic          y;
        logic          rdy;
        logic          pv;
        logic [LW-1:0] len;
        int            pk;
    } vec_t;

    vec_t          tbl [23];
    logic [PW-1:0] exp_pkt [4];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic apply(input logic v, input logic [FW-1:0] d, input logic y);
        bus.link_v_i    = v;
        bus.link_data_i = d;
        bus.pkt_yumi_i  = y;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mk(input logic [FW-1:0] h, input logic [FW-1:0] b1,
                                         input logic [FW-1:0] b2, input logic [FW-1:0] b3);
        logic [PW-1:0] p;
        p = '0;
        p[0*FW +: FW] = h;
        p[1*FW +: FW] = b1;
        p[2*FW +: FW] = b2;
        p[3*FW +: FW] = b3;
        return p;
    endfunction

    logic [PW-1:0] p8;

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus.link_v_i    = 1'b0;
        bus.link_data_i = '0;
        bus.pkt_yumi_i  = 1'b0;

        exp_pkt[0] = mk(64'h3A,  64'h0,  64'h0,  64'h0);
        exp_pkt[1] = mk(64'h305, 64'hA,  64'hB,  64'hC);
        exp_pkt[2] = mk(64'h207, 64'h11, 64'h12, 64'h0);
        exp_pkt[3] = mk(64'h209, 64'h21, 64'h22, 64'h0);

        //              v  data         y  rdy pv len pk
        tbl[0]  = '{1'b1, 64'h3A,   1'b0, 1'b1, 1'b0, 4'd0, -1};
        tbl[1]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 4'd0,  0};
        tbl[2]  = '{1'b1, 64'h305,  1'b0, 1'b1, 1'b0, 4'd0, -1};
        tbl[3]  = '{1'b1, 64'hA,    1'b0, 1'b1, 1'b0, 4'd3, -1};
        tbl[4]  = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 4'd3, -1};
        tbl[5]  = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 4'd3, -1};
        tbl[6]  = '{1'b1, 64'hB,    1'b0, 1'b1, 1'b0, 4'd3, -1};
        tbl[7]  = '{1'b1, 64'hC,    1'b0, 1'b1, 1'b0, 4'd3, -1};
        tbl[8]  = '{1'b0, 64'h0,    1'b0, 1'b0, 1'b1, 4'd3,  1};
        tbl[9]  = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 4'd3,  1};
        tbl[10] = '{1'b1, 64'h207,  1'b0, 1'b1, 1'b0, 4'd3, -1};
        tbl[11] = '{1'b1, 64'h11,   1'b0, 1'b1, 1'b0, 4'd2, -1};
        tbl[12] = '{1'b1, 64'h12,   1'b0, 1'b1, 1'b0, 4'd2, -1};
        tbl[13] = '{1'b1, 64'h209,  1'b1, 1'b1, 1'b1, 4'd2,  2};
        tbl[14] = '{1'b1, 64'h21,   1'b0, 1'b1, 1'b0, 4'd2, -1};
        tbl[15] = '{1'b1, 64'h22,   1'b0, 1'b1, 1'b0, 4'd2, -1};
        tbl[16] = '{1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 4'd2,  3};
        tbl[17] = '{1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 4'd2,  3};
        tbl[18] = '{1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 4'd2,  3};
        tbl[19] = '{1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 4'd2,  3};
        tbl[20] = '{1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 4'd2,  3};
        tbl[21] = '{1'b0, 64'h0,    1'b1, 1'b1, 1'b1, 4'd2,  3};
        tbl[22] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 4'd2, -1};

        // Reset state
        #3;
        chk("rst_ready", PW'(bus.link_ready_and_o), PW'(1'b0));
        chk("rst_pv",    PW'(bus.pkt_v_o),          PW'(1'b0));
        chk("rst_len",   PW'(bus.pkt_len_o),        PW'(0));
        chk("rst_err",   PW'(bus.err_o),            PW'(1'b0));
        chk("rst_pkt",   bus.pkt_o,                 '0);
        advance();
        rst_n = 1'b1;

        // Table: len=0, len=3 with bubbles, back-to-back len=2, FULL backpressure
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].y);
            chk($sformatf("t%0d_ready", i), PW'(bus.link_ready_and_o), PW'(tbl[i].rdy));
            chk($sformatf("t%0d_pv", i),    PW'(bus.pkt_v_o),          PW'(tbl[i].pv));
            chk($sformatf("t%0d_len", i),   PW'(bus.pkt_len_o),        PW'(tbl[i].len));
            chk($sformatf("t%0d_err", i),   PW'(bus.err_o),            PW'(1'b0));
            if (tbl[i].pk >= 0)
                chk($sformatf("t%0d_pkt", i), bus.pkt_o, exp_pkt[tbl[i].pk]);
            advance();
        end

        // Oversize len=12: drained, never valid, one err pulse
        apply(1'b1, 64'hC04, 1'b0);
        chk("drn_hdr_ready", PW'(bus.link_ready_and_o), PW'(1'b1));
        advance();
        for (int j = 0; j < 12; j++) begin
            apply(1'b1, FW'(64'h100 + j), 1'b0);
            chk($sformatf("drn%0d_ready", j), PW'(bus.link_ready_and_o), PW'(1'b1));
            chk($sformatf("drn%0d_pv", j),    PW'(bus.pkt_v_o),          PW'(1'b0));
            chk($sformatf("drn%0d_err", j),   PW'(bus.err_o),            PW'(1'b0));
            advance();
        end
        apply(1'b0, '0, 1'b0);
        chk("drn_err_pulse", PW'(bus.err_o),   PW'(1'b1));
        chk("drn_pv_end",    PW'(bus.pkt_v_o), PW'(1'b0));
        advance();
        apply(1'b1, 64'h101, 1'b0);
        chk("drn_err_once", PW'(bus.err_o), PW'(1'b0));
        chk("drn_idle_rdy", PW'(bus.link_ready_and_o), PW'(1'b1));
        advance();
        apply(1'b1, 64'h77, 1'b0);
        chk("after_drn_pv_lo", PW'(bus.pkt_v_o), PW'(1'b0));
        advance();
        apply(1'b0, '0, 1'b1);
        chk("after_drn_pv",  PW'(bus.pkt_v_o),   PW'(1'b1));
        chk("after_drn_len", PW'(bus.pkt_len_o), PW'(1));
        chk("after_drn_pkt", bus.pkt_o, mk(64'h101, 64'h77, 64'h0, 64'h0));
        advance();

        // Asynchronous reset after 2 of 5 body flits
        apply(1'b1, 64'h503, 1'b0);
        advance();
        apply(1'b1, 64'h31, 1'b0);
        advance();
        apply(1'b1, 64'h32, 1'b0);
        advance();
        bus.link_v_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", PW'(bus.link_ready_and_o), PW'(1'b0));
        chk("arst_pv",    PW'(bus.pkt_v_o),          PW'(1'b0));
        chk("arst_len",   PW'(bus.pkt_len_o),        PW'(0));
        chk("arst_pkt",   bus.pkt_o,                 '0);
        advance();
        rst_n = 1'b1;
        apply(1'b1, 64'h102, 1'b0);
        chk("arst_rel_ready", PW'(bus.link_ready_and_o), PW'(1'b1));
        advance();
        apply(1'b1, 64'h55, 1'b0);
        advance();
        apply(1'b0, '0, 1'b1);
        chk("arst_after_pv",  PW'(bus.pkt_v_o),   PW'(1'b1));
        chk("arst_after_len", PW'(bus.pkt_len_o), PW'(1));
        chk("arst_after_pkt", bus.pkt_o, mk(64'h102, 64'h55, 64'h0, 64'h0));
        advance();

        // len=8 boundary: buffer exactly full
        p8 = '0;
        p8[0 +: FW] = 64'h806;
        apply(1'b1, 64'h806, 1'b0);
        advance();
        for (int j = 1; j <= 8; j++) begin
            p8[j*FW +: FW] = FW'(64'h80 + j);
            apply(1'b1, FW'(64'h80 + j), 1'b0);
            chk($sformatf("max%0d_pv", j), PW'(bus.pkt_v_o), PW'(1'b0));
            advance();
        end
        apply(1'b0, '0, 1'b0);
        chk("max_pv",  PW'(bus.pkt_v_o),   PW'(1'b1));
        chk("max_len", PW'(bus.pkt_len_o), PW'(8));
        chk("max_pkt", bus.pkt_o, p8);
        chk("max_err", PW'(bus.err_o), PW'(1'b0));
        advance();
        apply(1'b0, '0, 1'b1);
        advance();
        apply(1'b0, '0, 1'b0);
        chk("max_idle_pv", PW'(bus.pkt_v_o), PW'(1'b0));
        advance();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
